// File: rtl/rv32i_inst_encoder_pkg.sv
// Shared RV32I definitions: opcode[6:2] class keys, instruction format enum and
// the class-to-format lookup used by both the encoder and the decoder.
package rv32i_inst_encoder_pkg;

  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_IMM    = 5'b00100;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_OP     = 5'b01100;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_JAL    = 5'b11011;

  typedef enum logic [2:0] {
    FMT_U,
    FMT_I,
    FMT_SH,
    FMT_S,
    FMT_B,
    FMT_J,
    FMT_R,
    FMT_ILL
  } fmt_e;

  // Shift-immediates share OP_IMM but carry func7[5] in the immediate slot.
  function automatic fmt_e op_fmt(input logic [4:0] op, input logic [2:0] f3);
    fmt_e f;
    case (op)
      OP_LUI, OP_AUIPC:         f = FMT_U;
      OP_LOAD, OP_JALR:         f = FMT_I;
      OP_IMM:                   f = (f3 == 3'b001 || f3 == 3'b101) ? FMT_SH : FMT_I;
      OP_OP:                    f = FMT_R;
      OP_STORE:                 f = FMT_S;
      OP_BRANCH:                f = FMT_B;
      OP_JAL:                   f = FMT_J;
      default:                  f = FMT_ILL;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/rv32i_inst_encoder_fifo.sv
// DEPTH x WIDTH synchronous FIFO with flush; callers must not push when full.
module rv32i_inst_encoder_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign full  = (cnt_q == CNT_W'(DEPTH));
  assign empty = (cnt_q == '0);
  assign rdata = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage carries no reset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/rv32i_inst_encoder.sv
// Packs field-level descriptors into RV32I words and streams them with imem addresses.
// Optional `ENC_RANGE_CHECK_EN: per-format immediate legality check plus drop_cnt port.
module rv32i_inst_encoder
  import rv32i_inst_encoder_pkg::*;
#(
  parameter int                DEPTH     = 4,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_func3,
  input  logic              in_f7b5,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err_illegal
`ifdef ENC_RANGE_CHECK_EN
  ,
  output logic [7:0]        drop_cnt
`endif
);

  fmt_e        fmt;
  logic [6:0]  opc;
  logic [31:0] enc_word;
  logic        range_ok;
  logic        accept, push, pop;
  logic        fifo_full, fifo_empty;
  logic [31:0] fifo_rdata;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              err_q, err_d;
  logic [31:0]       last_q, last_d;

  assign fmt = op_fmt(in_op, in_func3);
  assign opc = {in_op, 2'b11};

  always_comb begin
    enc_word = '0;
    case (fmt)
      FMT_U:  enc_word = {in_imm[31:12], in_rd, opc};
      FMT_I:  enc_word = {in_imm[11:0], in_rs1,
                          (in_op == OP_JALR) ? 3'b000 : in_func3, in_rd, opc};
      FMT_SH: enc_word = {1'b0, in_f7b5, 5'b0, in_imm[4:0], in_rs1, in_func3, in_rd, opc};
      FMT_R:  enc_word = {1'b0, in_f7b5, 5'b0, in_rs2, in_rs1, in_func3, in_rd, opc};
      FMT_S:  enc_word = {in_imm[11:5], in_rs2, in_rs1, in_func3, in_imm[4:0], opc};
      FMT_B:  enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_func3,
                          in_imm[4:1], in_imm[11], opc};
      FMT_J:  enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, opc};
      default: enc_word = '0;
    endcase
  end

`ifdef ENC_RANGE_CHECK_EN
  // Upper bits must be pure sign extension of the field's top bit.
  always_comb begin
    range_ok = 1'b1;
    case (fmt)
      FMT_I, FMT_S: range_ok = (in_imm[31:11] == '0) || (in_imm[31:11] == '1);
      FMT_B:        range_ok = ((in_imm[31:12] == '0) || (in_imm[31:12] == '1)) && !in_imm[0];
      FMT_J:        range_ok = ((in_imm[31:20] == '0) || (in_imm[31:20] == '1)) && !in_imm[0];
      FMT_U:        range_ok = (in_imm[11:0] == '0);
      FMT_SH:       range_ok = (in_imm[31:5] == '0);
      default:      range_ok = 1'b1;
    endcase
  end
`else
  logic unused_imm0;
  assign unused_imm0 = in_imm[0];
  assign range_ok    = 1'b1;
`endif

  // During flush the descriptor is taken but discarded so the producer never stalls on it.
  assign in_ready  = !fifo_full || flush;
  assign accept    = in_valid && in_ready;
  assign push      = accept && !flush && (fmt != FMT_ILL) && range_ok;
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready && !flush;
  assign out_inst  = fifo_empty ? last_q : fifo_rdata;
  assign out_addr  = addr_q;
  assign err_illegal = err_q;

  rv32i_inst_encoder_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .wdata (enc_word),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    addr_d = addr_q;
    err_d  = err_q;
    last_d = last_q;
    if (flush) begin
      addr_d = BASE_ADDR;
      err_d  = 1'b0;
    end else begin
      if (pop) begin
        addr_d = addr_q + ADDR_W'(4);
        last_d = fifo_rdata;
      end
      if (accept && fmt == FMT_ILL) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= BASE_ADDR;
      err_q  <= 1'b0;
      last_q <= '0;
    end else begin
      addr_q <= addr_d;
      err_q  <= err_d;
      last_q <= last_d;
    end
  end

`ifdef ENC_RANGE_CHECK_EN
  logic [7:0] drop_q, drop_d;

  always_comb begin
    drop_d = drop_q;
    if (flush)
      drop_d = '0;
    else if (accept && fmt != FMT_ILL && !range_ok && drop_q != 8'hFF)
      drop_d = drop_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_q <= '0;
    else        drop_q <= drop_d;
  end

  assign drop_cnt = drop_q;
`endif

endmodule

// File: tb/tb_rv32i_inst_encoder.sv
// Directed-vector bench for rv32i_inst_encoder with hand-computed RV32I words.
module tb_rv32i_inst_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_op = '0, in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [2:0]  in_func3 = '0;
  logic        in_f7b5 = 1'b0;
  logic [31:0] in_imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_inst;
  logic [31:0] out_addr;
  logic        err_illegal;
`ifdef ENC_RANGE_CHECK_EN
  logic [7:0]  drop_cnt;
`endif

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rv32i_inst_encoder #(
    .DEPTH     (4),
    .ADDR_W    (32),
    .BASE_ADDR (32'h0)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_rd       (in_rd),
    .in_rs1      (in_rs1),
    .in_rs2      (in_rs2),
    .in_func3    (in_func3),
    .in_f7b5     (in_f7b5),
    .in_imm      (in_imm),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_inst    (out_inst),
    .out_addr    (out_addr),
    .err_illegal (err_illegal)
`ifdef ENC_RANGE_CHECK_EN
    ,
    .drop_cnt    (drop_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic f7,
                        input logic [31:0] imm);
    in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_func3 = f3; in_f7b5 = f7; in_imm = imm;
  endtask

  // Presents one descriptor for exactly one clock; inputs change on negedges.
  task automatic send(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [2:0] f3, input logic f7,
                      input logic [31:0] imm);
    set_in(op, rd, rs1, rs2, f3, f7, imm);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic pop1();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  initial begin
    // reset state
    #2;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_inst", out_inst, 32'h0);
    chk("rst_out_addr", out_addr, 32'h0);
    chk("rst_err", {31'b0, err_illegal}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // addi x1,x0,5
    send(5'b00100, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd5);
    chk("addi_valid", {31'b0, out_valid}, 32'd1);
    chk("addi_inst", out_inst, 32'h00500093);
    chk("addi_addr", out_addr, 32'h0);
    pop1();
    chk("empty_valid", {31'b0, out_valid}, 32'd0);
    chk("empty_hold_inst", out_inst, 32'h00500093);
    chk("addr_after_pop", out_addr, 32'h4);

    // sub x3,x1,x2 ; beq x1,x2,-8
    do_flush();
    chk("flush_addr", out_addr, 32'h0);
    send(5'b01100, 5'd3, 5'd1, 5'd2, 3'b000, 1'b1, 32'd0);
    send(5'b11000, 5'd0, 5'd1, 5'd2, 3'b000, 1'b0, 32'hFFFF_FFF8);
    chk("sub_inst", out_inst, 32'h402081B3);
    chk("sub_addr", out_addr, 32'h0);
    pop1();
    chk("beq_inst", out_inst, 32'hFE208CE3);
    chk("beq_addr", out_addr, 32'h4);
    pop1();

    // jal x1,+2048 ; sw x5,-4(x2)
    do_flush();
    send(5'b11011, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd2048);
    send(5'b01000, 5'd0, 5'd2, 5'd5, 3'b010, 1'b0, 32'hFFFF_FFFC);
    chk("jal_inst", out_inst, 32'h001000EF);
    pop1();
    chk("sw_inst", out_inst, 32'hFE512E23);
    pop1();

    // srai x2,x3,7 ; lui x5,0x12345 ; jalr x0,0(x1) with func3 forced to 000
    send(5'b00100, 5'd2, 5'd3, 5'd0, 3'b101, 1'b1, 32'd7);
    send(5'b01101, 5'd5, 5'd0, 5'd0, 3'b000, 1'b0, 32'h1234_5000);
    send(5'b11001, 5'd0, 5'd1, 5'd0, 3'b111, 1'b0, 32'd0);
    chk("srai_inst", out_inst, 32'h4071D113);
    pop1();
    chk("lui_inst", out_inst, 32'h123452B7);
    pop1();
    chk("jalr_inst", out_inst, 32'h00008067);
    pop1();

    // fill to full with out_ready low, then drain while a fifth word waits
    do_flush();
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("fill_ready_%0d", k), {31'b0, in_ready}, 32'd1);
      send(5'b00100, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, k);
    end
    chk("full_in_ready", {31'b0, in_ready}, 32'd0);
    set_in(5'b00100, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd5);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    chk("full_pop_in_ready", {31'b0, in_ready}, 32'd0);
    chk("drain_w1", out_inst, 32'h00100093);
    chk("drain_a1", out_addr, 32'h0);
    @(negedge clk);
    chk("drain_w2", out_inst, 32'h00200093);
    chk("drain_a2", out_addr, 32'h4);
    chk("refill_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("drain_w3", out_inst, 32'h00300093);
    chk("drain_a3", out_addr, 32'h8);
    @(negedge clk);
    chk("drain_w4", out_inst, 32'h00400093);
    chk("drain_a4", out_addr, 32'hC);
    @(negedge clk);
    chk("drain_w5", out_inst, 32'h00500093);
    chk("drain_a5", out_addr, 32'h10);
    @(negedge clk);
    out_ready = 1'b0;
    chk("drained_valid", {31'b0, out_valid}, 32'd0);

    // illegal opcode class, sticky error, flush clears
    do_flush();
    send(5'b11111, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd0);
    chk("ill_no_output", {31'b0, out_valid}, 32'd0);
    chk("ill_err_set", {31'b0, err_illegal}, 32'd1);
    send(5'b00100, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd5);
    pop1();
    chk("ill_err_sticky", {31'b0, err_illegal}, 32'd1);
    chk("ill_addr_moved", out_addr, 32'h4);
    do_flush();
    chk("flush_err_clr", {31'b0, err_illegal}, 32'd0);
    chk("flush_addr_base", out_addr, 32'h0);

    // flush beats a simultaneous push
    set_in(5'b00100, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd9);
    in_valid = 1'b1;
    flush    = 1'b1;
    chk("flush_in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b0;
    chk("flush_no_push", {31'b0, out_valid}, 32'd0);

    // out-of-range immediate on addi
    send(5'b00100, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd4096);
`ifdef ENC_RANGE_CHECK_EN
    chk("range_dropped", {31'b0, out_valid}, 32'd0);
    chk("range_drop_cnt", {24'b0, drop_cnt}, 32'd1);
    do_flush();
    chk("drop_cnt_flush", {24'b0, drop_cnt}, 32'd0);
`else
    chk("trunc_valid", {31'b0, out_valid}, 32'd1);
    chk("trunc_inst", out_inst, 32'h00000093);
`endif

    // asynchronous reset mid-stream
    send(5'b00100, 5'd2, 5'd0, 5'd0, 3'b000, 1'b0, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'b0, out_valid}, 32'd0);
    chk("arst_inst", out_inst, 32'h0);
    chk("arst_addr", out_addr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
